lcs_engine: RTL and testbench

Parametrised longest-common-subsequence engine for the LCD string-entry lab. It takes two packed character strings, such as those built by the button/scroll entry FSM. It fills a dynamic-programming table one cell per clock, then backtracks to recover one LCS. It returns the length and an LCD-ready, space-padded LCS string that the top level shows on the "The length of / LCS = …" and "The LCS is" screens.

---
 rtl/lcs_engine.sv | 165 ++++++++++++++++
 tb/tb_lcs_engine.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcs_engine.sv
// Longest-common-subsequence engine: fills a DP table one cell per clock, then
// backtracks to produce the LCS length and a left-justified, PAD-filled string.
module lcs_engine #(
    parameter int unsigned   MAX_LEN = 16,
    parameter int unsigned   CW      = 8,
    parameter logic [CW-1:0] PAD     = CW'('h20),
    parameter int unsigned   LW      = $clog2(MAX_LEN + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [MAX_LEN*CW-1:0]  str_a,
    input  logic [LW-1:0]          len_a,
    input  logic [MAX_LEN*CW-1:0]  str_b,
    input  logic [LW-1:0]          len_b,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [LW-1:0]          lcs_len,
    output logic [MAX_LEN*CW-1:0]  lcs_str
);

    localparam int unsigned           IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LW-1:0]         MAXL = LW'(MAX_LEN);
    localparam logic [LW-1:0]         ONE  = LW'(1);
    localparam logic [LW-1:0]         TWO  = LW'(2);
    localparam logic [MAX_LEN*CW-1:0] PADS = {MAX_LEN{PAD}};

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FILL, S_TRACE, S_DONE} state_t;
    state_t state_q, state_d;

    logic [MAX_LEN*CW-1:0] a_q, b_q, lcs_str_q;
    logic [LW-1:0]         la_q, lb_q, i_q, j_q, k_q, lcs_len_q;
    logic                  err_q;
    // dp_q[r][c] holds dp[r+1][c+1]; row/column 0 of the table is implicit zero
    logic [LW-1:0]         dp_q [MAX_LEN][MAX_LEN];

    logic [LW-1:0] im1, im2, jm1, jm2;
    logic [LW-1:0] diag, up, left, cell_val, i_tr, j_tr;
    logic [CW-1:0] ch_a, ch_b;
    logic          match, trace_end, last_cell, req_ok, zero_len;
    int unsigned   str_off;

    function automatic logic [CW-1:0] char_at(input logic [MAX_LEN*CW-1:0] s,
                                              input logic [LW-1:0] pos);
        int unsigned p;
        p = 32'(pos);
        if (pos == '0 || pos > MAXL) return '0;
        return s[(MAX_LEN - p) * CW +: CW];
    endfunction

    always_comb begin
        im1       = i_q - ONE;
        im2       = i_q - TWO;
        jm1       = j_q - ONE;
        jm2       = j_q - TWO;
        ch_a      = char_at(a_q, i_q);
        ch_b      = char_at(b_q, j_q);
        match     = (ch_a == ch_b);
        diag      = (i_q < TWO || j_q < TWO) ? '0 : dp_q[im2[IW-1:0]][jm2[IW-1:0]];
        up        = (i_q < TWO || j_q == '0) ? '0 : dp_q[im2[IW-1:0]][jm1[IW-1:0]];
        left      = (i_q == '0 || j_q < TWO) ? '0 : dp_q[im1[IW-1:0]][jm2[IW-1:0]];
        cell_val  = match ? diag + ONE : ((up >= left) ? up : left);
        i_tr      = i_q;
        j_tr      = j_q;
        if (match) begin
            i_tr = im1;
            j_tr = jm1;
        end else if (up >= left) begin
            i_tr = im1;
        end else begin
            j_tr = jm1;
        end
        trace_end = (i_tr == '0) || (j_tr == '0);
        last_cell = (i_q == la_q) && (j_q == lb_q);
        req_ok    = (len_a <= MAXL) && (len_b <= MAXL);
        zero_len  = (la_q == '0) || (lb_q == '0);
        str_off   = (MAX_LEN - 32'd1 - 32'(k_q)) * CW;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // TRACE exits on the post-move indices, so an empty string skips it entirely
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = req_ok ? S_LOAD : S_DONE;
            S_LOAD:  state_d = zero_len ? S_DONE : S_FILL;
            S_FILL:  if (last_cell) state_d = S_TRACE;
            S_TRACE: if (trace_end) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_LOAD) || (state_q == S_FILL) || (state_q == S_TRACE);
        done = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q       <= '0;
            b_q       <= '0;
            la_q      <= '0;
            lb_q      <= '0;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            err_q     <= 1'b0;
            lcs_len_q <= '0;
            lcs_str_q <= PADS;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q       <= str_a;
                        b_q       <= str_b;
                        la_q      <= len_a;
                        lb_q      <= len_b;
                        lcs_len_q <= '0;
                        lcs_str_q <= PADS;
                        err_q     <= !req_ok;
                    end
                end
                S_LOAD: begin
                    i_q <= ONE;
                    j_q <= ONE;
                end
                S_FILL: begin
                    if (last_cell) begin
                        lcs_len_q <= cell_val;
                        k_q       <= cell_val - ONE;
                    end else if (j_q == lb_q) begin
                        i_q <= i_q + ONE;
                        j_q <= ONE;
                    end else begin
                        j_q <= j_q + ONE;
                    end
                end
                S_TRACE: begin
                    if (match) begin
                        lcs_str_q[str_off +: CW] <= ch_a;
                        k_q                      <= k_q - ONE;
                    end
                    i_q <= i_tr;
                    j_q <= j_tr;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_FILL) dp_q[im1[IW-1:0]][jm1[IW-1:0]] <= cell_val;
    end

    assign err     = err_q;
    assign lcs_len = lcs_len_q;
    assign lcs_str = lcs_str_q;

endmodule

// File: tb/tb_lcs_engine.sv
// Directed bench for lcs_engine: hand-computed lengths, strings and done latencies.
module tb_lcs_engine;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [127:0] str_a = '0;
    logic [127:0] str_b = '0;
    logic [4:0]   len_a = '0;
    logic [4:0]   len_b = '0;
    logic         busy, done, err;
    logic [4:0]   lcs_len;
    logic [127:0] lcs_str;

    int n_cmp = 0;
    int n_bad = 0;

    lcs_engine #(.MAX_LEN(16), .CW(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .str_a   (str_a),
        .len_a   (len_a),
        .str_b   (str_b),
        .len_b   (len_b),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .lcs_len (lcs_len),
        .lcs_str (lcs_str)
    );

    always #5 clk = ~clk;

    // Left-justify the low n chars of s and fill the rest with spaces.
    function automatic logic [127:0] lj(input logic [127:0] s, input int n);
        logic [127:0] r;
        r = s << (8 * (16 - n));
        for (int i = 0; i < 16 - n; i++) r[i*8 +: 8] = 8'h20;
        return r;
    endfunction

    task automatic run_req(input string tag, input logic [127:0] sa, input int la,
                           input logic [127:0] sb, input int lb, input int exp_done,
                           input logic exp_busy, input int exp_len,
                           input logic [127:0] exp_str, input logic exp_err,
                           input int pulse_at);
        int done_at;
        int busy_bad;
        @(negedge clk);
        str_a = sa;
        len_a = la[4:0];
        str_b = sb;
        len_b = lb[4:0];
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        done_at  = 0;
        busy_bad = 0;
        for (int n = 1; n <= 400; n++) begin
            if (n == 1 && exp_busy) begin
                n_cmp++;
                if (err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s err_in_load: got %b want 0", tag, err);
                end
            end
            if (done === 1'b1) begin
                done_at = n;
                break;
            end
            if (busy !== exp_busy) busy_bad++;
            if (n == pulse_at) begin
                str_a = lj("zz", 2);
                len_a = 5'd2;
                str_b = lj("zz", 2);
                len_b = 5'd2;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        n_cmp++;
        if (done_at !== exp_done) begin
            n_bad++;
            $display("FAIL %s done_cycle: got %0d want %0d", tag, done_at, exp_done);
        end
        n_cmp++;
        if (busy_bad !== 0) begin
            n_bad++;
            $display("FAIL %s busy_before_done: got %0d wrong cycles want 0", tag, busy_bad);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s busy_at_done: got %b want 0", tag, busy);
        end
        n_cmp++;
        if (lcs_len !== exp_len[4:0]) begin
            n_bad++;
            $display("FAIL %s lcs_len: got %0d want %0d", tag, lcs_len, exp_len);
        end
        n_cmp++;
        if (lcs_str !== exp_str) begin
            n_bad++;
            $display("FAIL %s lcs_str: got \"%s\" want \"%s\"", tag, lcs_str, exp_str);
        end
        n_cmp++;
        if (err !== exp_err) begin
            n_bad++;
            $display("FAIL %s err: got %b want %b", tag, err, exp_err);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s after_done: got done=%b busy=%b want 0 0", tag, done, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got busy=%b done=%b err=%b want 0 0 0", busy, done, err);
        end
        n_cmp++;
        if (lcs_len !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_len: got %0d want 0", lcs_len);
        end
        n_cmp++;
        if (lcs_str !== {16{8'h20}}) begin
            n_bad++;
            $display("FAIL reset_str: got %h want all 20", lcs_str);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        run_req("abcde_ace", lj("abcde", 5), 5, lj("ace", 3), 3, 22, 1'b1, 3,
                lj("ace", 3), 1'b0, 0);
    endtask

    task automatic test_identical();
        run_req("identical", lj("0816146", 7), 7, lj("0816146", 7), 7, 58, 1'b1, 7,
                lj("0816146", 7), 1'b0, 0);
    endtask

    task automatic test_error();
        run_req("len17", lj("abc", 3), 17, lj("abc", 3), 3, 1, 1'b0, 0,
                lj(128'h0, 0), 1'b1, 0);
    endtask

    task automatic test_tiebreak();
        run_req("ab_ba", lj("ab", 2), 2, lj("ba", 2), 2, 8, 1'b1, 1,
                lj("a", 1), 1'b0, 0);
    endtask

    task automatic test_nomatch();
        run_req("abc_xyz", lj("abc", 3), 3, lj("xyz", 3), 3, 14, 1'b1, 0,
                lj(128'h0, 0), 1'b0, 0);
    endtask

    task automatic test_empty();
        run_req("empty_a", lj(128'h0, 0), 0, lj("hello", 5), 5, 2, 1'b1, 0,
                lj(128'h0, 0), 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        run_req("b2b", lj("abcde", 5), 5, lj("ace", 3), 3, 22, 1'b1, 3,
                lj("ace", 3), 1'b0, 6);
    endtask

    task automatic test_reset_mid();
        int pulses;
        @(negedge clk);
        str_a = lj("abcde", 5);
        len_a = 5'd5;
        str_b = lj("ace", 3);
        len_b = 5'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_busy_before: got %b want 1", busy);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || lcs_len !== 5'd0) begin
            n_bad++;
            $display("FAIL rstmid_outputs: got busy=%b done=%b err=%b len=%0d want 0 0 0 0",
                     busy, done, err, lcs_len);
        end
        n_cmp++;
        if (lcs_str !== {16{8'h20}}) begin
            n_bad++;
            $display("FAIL rstmid_str: got %h want all 20", lcs_str);
        end
        reset  = 1'b0;
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++;
            $display("FAIL rstmid_no_done: got %0d active cycles want 0", pulses);
        end
        run_req("after_reset", lj("ab", 2), 2, lj("ba", 2), 2, 8, 1'b1, 1,
                lj("a", 1), 1'b0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_identical();
        test_error();
        test_tiebreak();
        test_nomatch();
        test_empty();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
